disp_scan_monitor: RTL and testbench
====================================

Name: disp_scan_monitor

Overview:
- Receive-side counterpart of the multiplexed 8-digit seven-segment display bus that the top level drives (codeout/seg).
- Samples the scanned bus on the fast system clock and debounces each digit select.
- Decodes the segment patterns back to BCD and reassembles a complete frame: mode digit plus HH MM SS.
- Used as an on-chip self-check monitor and as the front end for a remote display link.

Parameters:
- SETTLE_CYC, 16: consecutive cycles the digit select must be stable before codeout is captured.
- TIMEOUT_CYC, 100000: cycles without a completed frame before LINK_LOST asserts.
- SEL_ACTIVE_LOW, 1: 1 means seg[i]=0 selects digit i; 0 means seg[i]=1 selects it.
- SEG_ACTIVE_LOW, 0: 1 means codeout is inverted before decode (common-anode board).

Ports:
- CP  input  1  system clock (50 MHz); every register uses its rising edge.
- CR  input  1  reset, asynchronous, active-high; clears all state.
- codeout  input  8  segment bus {dp,g,f,e,d,c,b,a}.
- seg  input  8  digit select; bit i selects digit i; digit 0 is rightmost.
- Q_H  output  8  hours, BCD {tens,units}, taken from digits 5..4.
- Q_M  output  8  minutes, BCD, from digits 3..2.
- Q_S  output  8  seconds, BCD, from digits 1..0.
- MODE  output  4  decoded digit 6.
- DIGITS  output  32  all 8 decoded nibbles; digit i sits at [4i+3:4i].
- DP  output  8  dp bit captured per digit.
- FRAME_VALID  output  1  one-cycle pulse when the outputs above update.
- DEC_ERR  output  1  last committed frame contained an undecodable pattern.
- SEL_ERR  output  1  sticky: a non-one-hot, non-idle select was seen.
- LINK_LOST  output  1  no frame completed within TIMEOUT_CYC.
- RANGE_ERR  output  1  see Optional Feature.

Behaviour:
- Input sync: codeout and seg each pass through a 2-flop synchronizer. All latencies below are counted from the synchronized values.
- Polarity: after sync, seg is normalized to active-high per SEL_ACTIVE_LOW, and codeout per SEG_ACTIVE_LOW.
- Select classification (normalized): idle = 8'h00; valid = exactly one bit set; anything else is invalid.
- Invalid select: sets SEL_ERR and restarts the settle counter. Nothing is captured.
- Idle select: restarts the settle counter. It is not an error.
- Settle FSM, states WAIT and HOLD:
  - WAIT: a valid select loads it into sel_q, clears the counter and moves to HOLD.
  - HOLD: if the select equals sel_q, the counter increments. When it reaches SETTLE_CYC-1, codeout is captured for digit index(sel_q), capture mask bit i is set, and the FSM moves to DONE_DIGIT.
  - DONE_DIGIT: stays until the select changes, then returns to WAIT. Each scan slot therefore gives exactly one capture.
  - A select change while in HOLD returns the FSM to WAIT without capturing.
- Decode, bits 6..0, active-high:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 00 (blank) → 4'hA.
  - Any other pattern → 4'hF and sets the frame-local dec flag.
- Capture storage: a re-capture of a digit already in the mask overwrites its stored value.
- Commit: in the cycle after the mask becomes 8'hFF:
  - DIGITS, DP, Q_H, Q_M, Q_S, MODE and DEC_ERR update.
  - FRAME_VALID pulses high for 1 cycle.
  - The mask and dec flag clear.
  - The timeout counter clears and LINK_LOST deasserts.
- Timeout: the counter increments every cycle that has no commit. When it reaches TIMEOUT_CYC-1, LINK_LOST asserts and the counter saturates.
- Reset values:
  - All data outputs, DEC_ERR, SEL_ERR, FRAME_VALID and RANGE_ERR = 0.
  - LINK_LOST = 1, since no frame has been seen yet.
  - FSM = WAIT, mask = 0.
- CR asserted mid-frame discards any partial frame.
- SEL_ERR clears only on CR.

Optional Feature:
- Macro: DISP_SCAN_MONITOR_RANGE_CHECK_EN.
- When defined, RANGE_ERR updates at each commit. It is set if Q_H > 8'h23, Q_M > 8'h59, Q_S > 8'h59, or any of those six nibbles is ≥ 4'hA.
- When undefined, RANGE_ERR is tied to 0 and no compare logic is built.

Decomposition:
- Package disp_scan_pkg holds:
  - the ten segment-pattern constants, SEG_BLANK, NIB_BLANK=4'hA and NIB_BAD=4'hF;
  - the digit-field index constants: sec 0-1, min 2-3, hour 4-5, mode 6;
  - the settle FSM state enum.
- Sub-module seg7_to_bcd is purely combinational: 7-bit pattern in; nibble and bad flag out.
- The onehot-to-index function also lives in the package.

Test Plan:
- Reset then idle: scan 23:59:58, mode 2, with SETTLE_CYC=16 and each digit held 40 cycles, active-low select. Expected:
  - Q_H=23, Q_M=59, Q_S=58, MODE=2, blank digit 7 gives DIGITS[31:28]=A;
  - one FRAME_VALID pulse per 8-digit scan;
  - LINK_LOST falls after the first commit.
- Glitch: hold a digit for only 10 cycles. Expected: that digit is not captured and no commit happens until a full-length slot arrives.
- Select 8'b1111_1100 (two active, active-low): SEL_ERR latches 1, there is no capture, and SEL_ERR stays 1 until CR.
- Pattern 8'h55 on digit 0: the commit shows DIGITS[3:0]=F and DEC_ERR=1. The next clean frame commits with DEC_ERR=0.
- With CR pulsed after 5 digits, outputs return to reset values. The remaining 3 digits alone do not commit; a full scan does.
- Stop the scan for TIMEOUT_CYC cycles: LINK_LOST=1. With the macro defined, a 25:00:00 scan gives RANGE_ERR=1.

Source files
------------

// File: rtl/disp_scan_pkg.sv
// Shared constants, types and helpers for the seven-segment scan monitor.
package disp_scan_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, for digits 0..9 and blank.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] NIB_BLANK = 4'hA;
    localparam logic [3:0] NIB_BAD   = 4'hF;

    // Digit positions within the scanned frame (digit 0 is rightmost).
    localparam int DIG_SEC_LO  = 0;
    localparam int DIG_SEC_HI  = 1;
    localparam int DIG_MIN_LO  = 2;
    localparam int DIG_MIN_HI  = 3;
    localparam int DIG_HOUR_LO = 4;
    localparam int DIG_HOUR_HI = 5;
    localparam int DIG_MODE    = 6;

    typedef enum logic [1:0] {
        ST_WAIT       = 2'd0,
        ST_HOLD       = 2'd1,
        ST_DONE_DIGIT = 2'd2
    } settle_state_t;

    // Index of the set bit in a one-hot select (caller guarantees one-hot).
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD nibble decoder.
// Blank decodes to NIB_BLANK; anything unrecognised gives NIB_BAD and flags bad.
module seg7_to_bcd
    import disp_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       bad
);

    // Pattern lookup; unknown patterns are reported rather than guessed.
    always_comb begin
        nibble = NIB_BAD;
        bad    = 1'b0;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_BLANK: nibble = NIB_BLANK;
            default: begin
                nibble = NIB_BAD;
                bad    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/disp_scan_monitor.sv
// Receive-side monitor for the multiplexed 8-digit seven-segment bus.
// Debounces each digit select, decodes the segments and commits whole frames.
// Optional build macro: DISP_SCAN_MONITOR_RANGE_CHECK_EN (HH:MM:SS range check).
module disp_scan_monitor
    import disp_scan_pkg::*;
#(
    parameter int SETTLE_CYC     = 16,
    parameter int TIMEOUT_CYC    = 100000,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        CP,
    input  logic        CR,
    input  logic [7:0]  codeout,
    input  logic [7:0]  seg,
    output logic [7:0]  Q_H,
    output logic [7:0]  Q_M,
    output logic [7:0]  Q_S,
    output logic [3:0]  MODE,
    output logic [31:0] DIGITS,
    output logic [7:0]  DP,
    output logic        FRAME_VALID,
    output logic        DEC_ERR,
    output logic        SEL_ERR,
    output logic        LINK_LOST,
    output logic        RANGE_ERR
);

    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYC - 1);
    localparam logic [TOW-1:0] TIMEOUT_LAST = TOW'(TIMEOUT_CYC - 1);
    // Select synchronizer resets to the idle bus level so that reset release
    // is not mistaken for an all-digits-selected glitch.
    localparam logic [7:0] SEL_IDLE_RAW = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0]     code_meta_r, code_sync_r, sel_meta_r, sel_sync_r;
    logic [7:0]     sel_norm_s, code_norm_s;
    logic           sel_idle_s, sel_onehot_s, sel_invalid_s;
    settle_state_t  state_r, state_nxt_s;
    logic [7:0]     sel_q_r, sel_q_nxt_s;
    logic [SCW-1:0] cnt_r, cnt_nxt_s;
    logic           capture_s, commit_s;
    logic [2:0]     cap_idx_s;
    logic [3:0]     dec_nib_s;
    logic           dec_bad_s;
    logic [31:0]    buf_dig_r;
    logic [7:0]     buf_dp_r, mask_r;
    logic           dec_flag_r;
    logic [31:0]    digits_r;
    logic [7:0]     dp_r;
    logic           fv_r, dec_err_r, sel_err_r, link_lost_r;
    logic [TOW-1:0] tmo_r;

    // Two-flop synchronizers for the asynchronous display bus.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            code_meta_r <= 8'h00;
            code_sync_r <= 8'h00;
            sel_meta_r  <= SEL_IDLE_RAW;
            sel_sync_r  <= SEL_IDLE_RAW;
        end else begin
            code_meta_r <= codeout;
            code_sync_r <= code_meta_r;
            sel_meta_r  <= seg;
            sel_sync_r  <= sel_meta_r;
        end
    end

    assign sel_norm_s    = SEL_ACTIVE_LOW ? ~sel_sync_r  : sel_sync_r;
    assign code_norm_s   = SEG_ACTIVE_LOW ? ~code_sync_r : code_sync_r;
    assign sel_idle_s    = (sel_norm_s == 8'h00);
    assign sel_onehot_s  = !sel_idle_s && ((sel_norm_s & (sel_norm_s - 8'd1)) == 8'h00);
    assign sel_invalid_s = !sel_idle_s && !sel_onehot_s;

    assign cap_idx_s = onehot_to_idx(sel_q_r);
    assign commit_s  = (mask_r == 8'hFF);

    seg7_to_bcd u_dec (
        .pattern (code_norm_s[6:0]),
        .nibble  (dec_nib_s),
        .bad     (dec_bad_s)
    );

    // Settle FSM state, latched select and stability counter.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_r <= ST_WAIT;
            sel_q_r <= 8'h00;
            cnt_r   <= {SCW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sel_q_r <= sel_q_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Settle FSM next state: one capture per stable scan slot.
    always_comb begin
        state_nxt_s = state_r;
        sel_q_nxt_s = sel_q_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_WAIT: begin
                cnt_nxt_s = {SCW{1'b0}};
                if (sel_onehot_s) begin
                    sel_q_nxt_s = sel_norm_s;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (sel_norm_s == sel_q_r) begin
                    cnt_nxt_s = cnt_r + 1'b1;
                    if ((cnt_r + 1'b1) >= SETTLE_LAST) begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_DONE_DIGIT;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    cnt_nxt_s   = {SCW{1'b0}};
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE_DIGIT: begin
                if (sel_norm_s != sel_q_r) begin
                    cnt_nxt_s   = {SCW{1'b0}};
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_DONE_DIGIT;
                end
            end
            default: begin
                cnt_nxt_s   = {SCW{1'b0}};
                state_nxt_s = ST_WAIT;
            end
        endcase
    end

    // Frame assembly buffer; a commit empties it (capture never coincides).
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            buf_dig_r  <= 32'h0000_0000;
            buf_dp_r   <= 8'h00;
            mask_r     <= 8'h00;
            dec_flag_r <= 1'b0;
        end else if (commit_s) begin
            mask_r     <= 8'h00;
            dec_flag_r <= 1'b0;
        end else if (capture_s) begin
            buf_dig_r[{cap_idx_s, 2'b00} +: 4] <= dec_nib_s;
            buf_dp_r[cap_idx_s]                <= code_norm_s[7];
            mask_r[cap_idx_s]                  <= 1'b1;
            dec_flag_r                         <= dec_flag_r | dec_bad_s;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Committed outputs, frame pulse and sticky select error.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            digits_r  <= 32'h0000_0000;
            dp_r      <= 8'h00;
            dec_err_r <= 1'b0;
            fv_r      <= 1'b0;
            sel_err_r <= 1'b0;
        end else begin
            fv_r      <= commit_s;
            sel_err_r <= sel_err_r | sel_invalid_s;
            if (commit_s) begin
                digits_r  <= buf_dig_r;
                dp_r      <= buf_dp_r;
                dec_err_r <= dec_flag_r;
            end else begin
                dec_err_r <= dec_err_r;
            end
        end
    end

    // Link watchdog: saturating count of cycles since the last commit.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            tmo_r       <= {TOW{1'b0}};
            link_lost_r <= 1'b1;
        end else if (commit_s) begin
            tmo_r       <= {TOW{1'b0}};
            link_lost_r <= 1'b0;
        end else if ((tmo_r + 1'b1) >= TIMEOUT_LAST) begin
            tmo_r       <= TIMEOUT_LAST;
            link_lost_r <= 1'b1;
        end else begin
            tmo_r       <= tmo_r + 1'b1;
        end
    end

`ifdef DISP_SCAN_MONITOR_RANGE_CHECK_EN
    logic [7:0] hh_s, mm_s, ss_s;
    logic       range_bad_s, range_err_r;

    assign hh_s = {buf_dig_r[DIG_HOUR_HI*4 +: 4], buf_dig_r[DIG_HOUR_LO*4 +: 4]};
    assign mm_s = {buf_dig_r[DIG_MIN_HI*4 +: 4],  buf_dig_r[DIG_MIN_LO*4 +: 4]};
    assign ss_s = {buf_dig_r[DIG_SEC_HI*4 +: 4],  buf_dig_r[DIG_SEC_LO*4 +: 4]};
    assign range_bad_s = (hh_s > 8'h23) || (mm_s > 8'h59) || (ss_s > 8'h59) ||
                         (hh_s[7:4] >= 4'hA) || (hh_s[3:0] >= 4'hA) ||
                         (mm_s[7:4] >= 4'hA) || (mm_s[3:0] >= 4'hA) ||
                         (ss_s[7:4] >= 4'hA) || (ss_s[3:0] >= 4'hA);

    // Time-of-day plausibility of the frame being committed.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            range_err_r <= 1'b0;
        end else if (commit_s) begin
            range_err_r <= range_bad_s;
        end else begin
            range_err_r <= range_err_r;
        end
    end

    assign RANGE_ERR = range_err_r;
`else
    assign RANGE_ERR = 1'b0;
`endif

    assign DIGITS      = digits_r;
    assign DP          = dp_r;
    assign Q_H         = {digits_r[DIG_HOUR_HI*4 +: 4], digits_r[DIG_HOUR_LO*4 +: 4]};
    assign Q_M         = {digits_r[DIG_MIN_HI*4 +: 4],  digits_r[DIG_MIN_LO*4 +: 4]};
    assign Q_S         = {digits_r[DIG_SEC_HI*4 +: 4],  digits_r[DIG_SEC_LO*4 +: 4]};
    assign MODE        = digits_r[DIG_MODE*4 +: 4];
    assign FRAME_VALID = fv_r;
    assign DEC_ERR     = dec_err_r;
    assign SEL_ERR     = sel_err_r;
    assign LINK_LOST   = link_lost_r;

endmodule

// File: tb/tb_disp_scan_monitor.sv
// Randomized self-checking bench for disp_scan_monitor with a frame-level model.
module tb_disp_scan_monitor;

    localparam int SETTLE    = 16;
    localparam int TMO       = 2000;
    localparam int LONG_MIN  = SETTLE + 6;
    localparam int LONG_MAX  = 40;
    localparam int SHORT_MIN = 3;
    localparam int SHORT_MAX = SETTLE - 4;

    logic        CP = 1'b0;
    logic        CR = 1'b1;
    logic [7:0]  codeout = 8'h00;
    logic [7:0]  seg = 8'hFF;
    logic [7:0]  Q_H, Q_M, Q_S, DP;
    logic [3:0]  MODE;
    logic [31:0] DIGITS;
    logic        FRAME_VALID, DEC_ERR, SEL_ERR, LINK_LOST, RANGE_ERR;

    disp_scan_monitor #(
        .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO),
        .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .CP(CP), .CR(CR), .codeout(codeout), .seg(seg),
        .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S), .MODE(MODE), .DIGITS(DIGITS), .DP(DP),
        .FRAME_VALID(FRAME_VALID), .DEC_ERR(DEC_ERR), .SEL_ERR(SEL_ERR),
        .LINK_LOST(LINK_LOST), .RANGE_ERR(RANGE_ERR)
    );

    always #10 CP = ~CP;

    int cyc = 0;
    int fv_cnt = 0;
    int last_fv_cyc = 0;
    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state: frame in progress and expected committed outputs.
    logic [7:0]  m_mask = 8'h00;
    logic [31:0] m_dig = 32'h0;
    logic [7:0]  m_dp = 8'h00;
    bit          m_dec = 1'b0;
    logic [31:0] exp_digits = 32'h0;
    logic [7:0]  exp_dp = 8'h00;
    bit          exp_dec = 1'b0, exp_sel = 1'b0, exp_ll = 1'b1, exp_range = 1'b0;
    int          exp_fv = 0;

    always @(posedge CP) cyc <= cyc + 1;

    always @(negedge CP) begin
        if (FRAME_VALID) begin
            fv_cnt      <= fv_cnt + 1;
            last_fv_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] enc7(input logic [3:0] n);
        case (n)
            4'h0: enc7 = 7'h3F;  4'h1: enc7 = 7'h06;  4'h2: enc7 = 7'h5B;
            4'h3: enc7 = 7'h4F;  4'h4: enc7 = 7'h66;  4'h5: enc7 = 7'h6D;
            4'h6: enc7 = 7'h7D;  4'h7: enc7 = 7'h07;  4'h8: enc7 = 7'h7F;
            4'h9: enc7 = 7'h6F;
            default: enc7 = 7'h00;
        endcase
    endfunction

    // A digit held long enough is stored; a full set of 8 commits the frame.
    task automatic model_capture(input logic [2:0] d, input logic [7:0] pat);
        logic [3:0] nib;
        bit bad;
        int di;
        logic [7:0] h, m, s;
        di  = int'(d);
        nib = 4'hF;
        bad = 1'b1;
        if (pat[6:0] == 7'h00) begin nib = 4'hA; bad = 1'b0; end
        for (int k = 0; k < 10; k++) begin
            if (pat[6:0] == enc7(4'(k))) begin nib = 4'(k); bad = 1'b0; end
        end
        m_dig[di*4 +: 4] = nib;
        m_dp[di]         = pat[7];
        m_mask[di]       = 1'b1;
        m_dec            = m_dec | bad;
        if (m_mask == 8'hFF) begin
            exp_digits = m_dig;
            exp_dp     = m_dp;
            exp_dec    = m_dec;
            exp_fv++;
            exp_ll     = 1'b0;
            h = exp_digits[23:16]; m = exp_digits[15:8]; s = exp_digits[7:0];
`ifdef DISP_SCAN_MONITOR_RANGE_CHECK_EN
            exp_range = (h > 8'h23) || (m > 8'h59) || (s > 8'h59) ||
                        (h[7:4] > 4'h9) || (h[3:0] > 4'h9) || (m[7:4] > 4'h9) ||
                        (m[3:0] > 4'h9) || (s[7:4] > 4'h9) || (s[3:0] > 4'h9);
`else
            exp_range = 1'b0;
`endif
            m_mask = 8'h00;
            m_dec  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        seg = 8'hFF;
        repeat (n) @(negedge CP);
    endtask

    task automatic slot(input logic [2:0] d, input logic [7:0] pat, input int len);
        seg     = ~(8'h01 << d);
        codeout = pat;
        repeat (len) @(negedge CP);
        if (len >= LONG_MIN) model_capture(d, pat);
    endtask

    task automatic scan(input logic [31:0] nibs, input logic [7:0] bad, input bit glitchy);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            if (glitchy && ($urandom_range(0, 2) == 0)) begin
                idle(2);
                slot(3'($urandom_range(0, 7)), {1'b0, enc7(4'($urandom_range(0, 9)))},
                     $urandom_range(SHORT_MIN, SHORT_MAX));
                idle(2);
            end
            pat = {1'($urandom_range(0, 1)), bad[i] ? 7'h55 : enc7(nibs[i*4 +: 4])};
            slot(3'(i), pat, glitchy ? $urandom_range(LONG_MIN, LONG_MAX) : LONG_MAX);
        end
        idle(6);
    endtask

    task automatic do_reset();
        CR = 1'b1; seg = 8'hFF; codeout = 8'h00;
        repeat (3) @(negedge CP);
        CR = 1'b0;
        m_mask = 8'h00; m_dec = 1'b0; m_dig = 32'h0; m_dp = 8'h00;
        exp_digits = 32'h0; exp_dp = 8'h00; exp_dec = 1'b0; exp_sel = 1'b0;
        exp_ll = 1'b1; exp_range = 1'b0;
        repeat (4) @(negedge CP);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "/fv_cnt"}, fv_cnt, exp_fv);
        check({tag, "/digits"}, DIGITS, exp_digits);
        check({tag, "/q_h"}, {24'h0, Q_H}, {24'h0, exp_digits[23:16]});
        check({tag, "/q_m"}, {24'h0, Q_M}, {24'h0, exp_digits[15:8]});
        check({tag, "/q_s"}, {24'h0, Q_S}, {24'h0, exp_digits[7:0]});
        check({tag, "/mode"}, {28'h0, MODE}, {28'h0, exp_digits[27:24]});
        check({tag, "/dp"}, {24'h0, DP}, {24'h0, exp_dp});
        check({tag, "/dec_err"}, {31'h0, DEC_ERR}, {31'h0, exp_dec});
        check({tag, "/sel_err"}, {31'h0, SEL_ERR}, {31'h0, exp_sel});
        check({tag, "/link_lost"}, {31'h0, LINK_LOST}, {31'h0, exp_ll});
        check({tag, "/range_err"}, {31'h0, RANGE_ERR}, {31'h0, exp_range});
        check({tag, "/frame_valid"}, {31'h0, FRAME_VALID}, 32'h0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CP);
    endtask

    initial begin
        do_reset();
        check_frame("reset");

        // 23:59:58, mode 2, blank digit 7; two scans give two pulses.
        scan(32'hA223_5958, 8'h00, 1'b0);
        check_frame("frame1");
        check("frame1/blank7", {28'h0, DIGITS[31:28]}, 32'hA);
        scan(32'hA223_5958, 8'h00, 1'b0);
        check_frame("frame2");

        // Digit 7 glitch-short: no commit until a full slot arrives.
        for (int i = 0; i < 7; i++) slot(3'(i), {1'b0, enc7(4'(i))}, LONG_MAX);
        slot(3'd7, {1'b1, enc7(4'h9)}, 10);
        idle(6);
        check_frame("glitch");
        slot(3'd7, {1'b1, enc7(4'h9)}, LONG_MAX);
        idle(6);
        check_frame("glitch_fix");

        // Two selects active at once: sticky error, no capture.
        idle(2);
        seg = 8'hFC; codeout = {1'b0, enc7(4'h3)};
        repeat (30) @(negedge CP);
        exp_sel = 1'b1;
        idle(4);
        check_frame("sel_err");

        // Undecodable pattern on digit 0, then a clean frame.
        scan(32'h1012_3456, 8'h01, 1'b0);
        check_frame("bad_pat");
        check("bad_pat/nib0", {28'h0, DIGITS[3:0]}, 32'hF);
        scan(32'h1012_3457, 8'h00, 1'b0);
        check_frame("clean_after_bad");

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 5; i++) slot(3'(i), {1'b0, enc7(4'(i + 2))}, LONG_MAX);
        do_reset();
        check_frame("mid_reset");
        for (int i = 5; i < 8; i++) slot(3'(i), {1'b0, enc7(4'(i))}, LONG_MAX);
        idle(6);
        check_frame("partial");
        scan(32'h0312_4501, 8'h00, 1'b0);
        check_frame("after_reset");

        // Randomized frames with glitch slots and occasional bad patterns.
        for (int f = 0; f < 8; f++) begin
            logic [31:0] nibs;
            logic [7:0]  bad;
            for (int n = 0; n < 8; n++) nibs[n*4 +: 4] = 4'($urandom_range(0, 10));
            bad = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            scan(nibs, bad, 1'b1);
            check_frame("random");
        end

        // Out-of-range hour.
        scan(32'hA125_0000, 8'h00, 1'b0);
        check_frame("range");

        // Stop scanning: LINK_LOST rises near TIMEOUT_CYC after the last commit.
        seg = 8'hFF;
        wait_cyc(last_fv_cyc + TMO - 10);
        check("timeout/before", {31'h0, LINK_LOST}, 32'h0);
        wait_cyc(last_fv_cyc + TMO + 10);
        exp_ll = 1'b1;
        check_frame("timeout");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
